// File: rtl/mem_array_ctrl.sv
// mem_array_ctrl: parametrised single-port synchronous memory with a
// valid/ready request port, an RD_LAT-stage read-response pipeline,
// a zero-fill sweep after reset or clear, and out-of-range error reporting.
module mem_array_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_err,
    output logic              init_done
);

    localparam int unsigned     IDX_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              addr_ok;
    logic [IDX_W-1:0]  idx;
    logic              rd_acc;
    logic              wr_acc;

    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_err;
    logic [DATA_W-1:0] pipe_data [RD_LAT];

    // Unsigned range check; one extra bit lets DEPTH == 2**ADDR_W admit every address.
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_X);
    assign idx       = req_addr[IDX_W-1:0];

    assign init_done = (state_q == RUN);
    assign req_ready = (state_q == RUN) && !clear;
    assign rd_acc    = req_valid && req_ready && !req_write;
    assign wr_acc    = req_valid && req_ready && req_write;

    // State and sweep counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state logic: sweep DEPTH words in INIT, leave RUN on clear.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            INIT: begin
                if (sweep_q == LAST) begin
                    state_d = RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + IDX_W'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Array write port: zero-fill during the sweep, request writes in RUN.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[sweep_q] <= '0;
        end else if (wr_acc && addr_ok) begin
            mem[idx] <= req_wdata;
        end
    end

    // Dropped out-of-range write reported one cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_acc && !addr_ok;
        end
    end

    // Read pipeline stage 0: sample the array at the acceptance edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld[0]  <= 1'b0;
            pipe_err[0]  <= 1'b0;
            pipe_data[0] <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            pipe_err[0] <= rd_acc && !addr_ok;
            if (rd_acc) begin
                pipe_data[0] <= addr_ok ? mem[idx] : '0;
            end
        end
    end

    // Remaining stages; data only advances with a valid so the output holds between responses.
    for (genvar s = 1; s < RD_LAT; s++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_vld[s]  <= 1'b0;
                pipe_err[s]  <= 1'b0;
                pipe_data[s] <= '0;
            end else begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_err[s] <= pipe_err[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_vld[RD_LAT-1];
    assign rsp_err   = pipe_err[RD_LAT-1];
    assign rsp_rdata = pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Randomised and directed bench for mem_array_ctrl. Two instances:
// A (DEPTH=32=2**ADDR_W, RD_LAT=1) and B (DEPTH=20, RD_LAT=3), exercised
// one at a time against a transaction-level reference model.
module tb_mem_array_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       req_valid;
    logic       req_write;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       sel;

    logic       a_clear, a_valid, a_ready, a_rsp_valid, a_rsp_err, a_wr_err, a_init;
    logic [7:0] a_rdata;
    logic       b_clear, b_valid, b_ready, b_rsp_valid, b_rsp_err, b_wr_err, b_init;
    logic [7:0] b_rdata;

    logic       o_ready, o_rsp_valid, o_rsp_err, o_wr_err, o_init;
    logic [7:0] o_rdata;

    always #5 clk = ~clk;

    assign a_clear = clear & ~sel;
    assign a_valid = req_valid & ~sel;
    assign b_clear = clear & sel;
    assign b_valid = req_valid & sel;

    assign o_ready     = sel ? b_ready     : a_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign o_wr_err    = sel ? b_wr_err    : a_wr_err;
    assign o_init      = sel ? b_init      : a_init;
    assign o_rdata     = sel ? b_rdata     : a_rdata;

    mem_array_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err),
        .wr_err(a_wr_err), .init_done(a_init)
    );

    mem_array_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(20), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err),
        .wr_err(b_wr_err), .init_done(b_init)
    );

    // Reference model: memory image, expected responses keyed by due cycle.
    typedef struct {
        int unsigned due;
        logic [7:0]  d;
        logic        e;
    } rsp_t;

    logic [7:0]  mdl_mem [32];
    rsp_t        rsp_q [$];
    int unsigned depth;
    int unsigned lat;
    int unsigned cyc;
    bit          m_run;
    int unsigned left;
    logic [7:0]  last_d;
    bit          exp_wr_err;

    int unsigned n_total;
    int unsigned n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rsp_q.delete();
        m_run      = 1'b0;
        left       = depth;
        last_d     = '0;
        exp_wr_err = 1'b0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
        check({tag, "_rdata"}, {24'd0, o_rdata}, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, o_rsp_err}, 32'd0);
        check({tag, "_wr_err"}, {31'd0, o_wr_err}, 32'd0);
        check({tag, "_init_done"}, {31'd0, o_init}, 32'd0);
    endtask

    // One clock: check combinational outputs, advance model at the edge, check registered outputs.
    task automatic step();
        bit   acc;
        rsp_t r;
        bit   exp_v;
        logic [7:0] exp_d;
        bit   exp_e;
        #1;
        check("req_ready", {31'd0, o_ready}, {31'd0, (m_run && !clear)});
        check("init_done", {31'd0, o_init}, {31'd0, m_run});
        acc = req_valid && m_run && !clear;
        @(posedge clk);
        cyc++;
        exp_wr_err = 1'b0;
        if (acc) begin
            if (req_write) begin
                if (req_addr < depth) mdl_mem[req_addr] = req_wdata;
                else exp_wr_err = 1'b1;
            end else begin
                r.due = cyc + lat - 1;
                r.d   = (req_addr < depth) ? mdl_mem[req_addr] : 8'h00;
                r.e   = (req_addr >= depth);
                rsp_q.push_back(r);
            end
        end
        if (!m_run) begin
            left--;
            if (left == 0) m_run = 1'b1;
        end else if (clear) begin
            m_run = 1'b0;
            left  = depth;
            for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
        end
        #1;
        exp_v = 1'b0;
        exp_e = 1'b0;
        exp_d = last_d;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r      = rsp_q.pop_front();
            exp_v  = 1'b1;
            exp_d  = r.d;
            exp_e  = r.e;
            last_d = r.d;
        end
        check("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, exp_v});
        check("rsp_rdata", {24'd0, o_rdata}, {24'd0, exp_d});
        check("rsp_err", {31'd0, o_rsp_err}, {31'd0, exp_e});
        check("wr_err", {31'd0, o_wr_err}, {31'd0, exp_wr_err});
    endtask

    task automatic idle();
        req_valid = 1'b0;
        clear     = 1'b0;
        step();
    endtask

    task automatic rd(input logic [4:0] a);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        clear     = 1'b0;
        step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        clear     = 1'b0;
        step();
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b0;
        #1;
        check_idle_outputs("rst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_idle_outputs("rst_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Idle until init_done; optionally require the sweep to take exactly depth edges.
    task automatic wait_init(input bit check_len);
        int unsigned cnt;
        cnt = 0;
        while (!o_init && cnt < 200) begin
            idle();
            cnt++;
        end
        if (check_len) check("init_len", cnt, depth);
        else check("init_reached", {31'd0, o_init}, 32'd1);
    endtask

    task automatic directed();
        rd(5'd0);
        rd(5'd15);
        rd(5'(depth - 1));
        wr(5'd5, 8'h41);
        rd(5'd5);
        repeat (4) idle();
        wr(5'd25, 8'hAA);
        rd(5'd25);
        rd(5'd19);
        repeat (4) idle();
        wr(5'd1, 8'h11);
        wr(5'd2, 8'h22);
        wr(5'd3, 8'h33);
        rd(5'd1);
        rd(5'd2);
        rd(5'd3);
        repeat (4) idle();
        wr(5'd4, 8'h7F);
        rd(5'd4);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd4;
        clear     = 1'b1;
        step();
        wait_init(1'b1);
        rd(5'd4);
        repeat (4) idle();
    endtask

    task automatic random_ops(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 5'($urandom_range(0, 31));
            req_wdata = 8'($urandom);
            clear     = ($urandom_range(0, 39) == 0);
            step();
        end
        repeat (5) idle();
        wait_init(1'b0);
    endtask

    task automatic reset_in_flight();
        rd(5'd3);
        rd(5'd7);
        req_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (4) begin
            @(posedge clk);
            #1;
            check_idle_outputs("abort_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        wait_init(1'b1);
        rd(5'd3);
        rd(5'd7);
        repeat (4) idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_total   = 0;
        n_pass    = 0;
        cyc       = 0;
        rst       = 1'b0;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int s = 0; s < 2; s++) begin
            sel   = (s == 1);
            depth = (s == 1) ? 20 : 32;
            lat   = (s == 1) ? 3 : 1;
            do_reset();
            wait_init(1'b1);
            directed();
            random_ops(300);
            reset_in_flight();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
